// File: rtl/hazard3_pmp_cfg_sequencer_pkg.sv
// Shared constants and address helpers for the boot-time PMP programmer.
package hazard3_pmp_cfg_sequencer_pkg;

    // CSR numbers of the first PMP config and address registers
    localparam logic [11:0] PMPCFG0  = 12'h3a0;
    localparam logic [11:0] PMPADDR0 = 12'h3b0;

    // pmpcfg CSR holding the byte of region k (four regions per 32-bit word)
    function automatic logic [11:0] pmpcfg_csr(input logic [31:0] k);
        return PMPCFG0 + 12'(k >> 2);
    endfunction

    // pmpaddr CSR of region k
    function automatic logic [11:0] pmpaddr_csr(input logic [31:0] k);
        return PMPADDR0 + 12'(k);
    endfunction

endpackage

// File: rtl/hazard3_pmp_cfg_sequencer.sv
// Boot-time PMP programmer. Owns the PMP cfg port: after reset (or a start
// pulse in IDLE) it writes each preloaded region's pmpaddr, read-modify-writes
// its pmpcfg byte, reads the byte back and records any mismatch in a sticky
// error flag. In IDLE the CSR block is passed straight through to the PMP.
module hazard3_pmp_cfg_sequencer
    import hazard3_pmp_cfg_sequencer_pkg::*;
#(
    parameter int                          W_DATA       = 32,
    parameter int                          PMP_REGIONS  = 4,
    parameter int                          N_PRELOAD    = 2,
    parameter logic [8*PMP_REGIONS-1:0]    PRELOAD_CFG  = '0,
    parameter logic [32*PMP_REGIONS-1:0]   PRELOAD_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [11:0]       csr_addr,
    input  logic              csr_wen,
    input  logic [W_DATA-1:0] csr_wdata,
    output logic [W_DATA-1:0] csr_rdata,
    output logic              csr_stall,
    output logic [11:0]       pmp_cfg_addr,
    output logic              pmp_cfg_wen,
    output logic [W_DATA-1:0] pmp_cfg_wdata,
    input  logic [W_DATA-1:0] pmp_cfg_rdata,
    output logic              busy,
    output logic              done,
    output logic              error
);

    if (N_PRELOAD < 0 || N_PRELOAD > PMP_REGIONS || PMP_REGIONS < 1 ||
        PMP_REGIONS > 16 || W_DATA < 32) begin : g_param_check
        $error("hazard3_pmp_cfg_sequencer: need 0 <= N_PRELOAD <= PMP_REGIONS <= 16 and W_DATA >= 32");
    end

    localparam int K_W = (N_PRELOAD > 0) ? $clog2(N_PRELOAD + 1) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'((N_PRELOAD > 0) ? N_PRELOAD - 1 : 0);

    typedef enum logic [2:0] {
        S_RESET,
        S_WR_ADDR,
        S_RD_CFG,
        S_WR_CFG,
        S_VERIFY,
        S_FINISH,
        S_IDLE
    } state_t;

    state_t              state_q, state_d;
    logic [K_W-1:0]      k_q, k_d;
    logic                error_q, error_d;
    logic [W_DATA-1:0]   cfg_hold_q, cfg_hold_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [31:0]         kk;
    logic [31:0]         byte_sel;
    logic [7:0]          preload_byte;
    logic [7:0]          readback_byte;
    logic [W_DATA-1:0]   merged_cfg;
    logic [11:0]         fsm_addr;
    logic                fsm_wen;
    logic [W_DATA-1:0]   fsm_wdata;
    logic                idle;

    // Sequencer next-state, region bookkeeping and the FSM's own view of the cfg port
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        error_d       = error_q;
        cfg_hold_d    = cfg_hold_q;
        fsm_addr      = '0;
        fsm_wen       = 1'b0;
        fsm_wdata     = '0;
        kk            = 32'(k_q);
        byte_sel      = {30'd0, kk[1:0]};
        preload_byte  = PRELOAD_CFG[8*kk +: 8];
        readback_byte = pmp_cfg_rdata[8*byte_sel +: 8];
        merged_cfg    = cfg_hold_q;
        merged_cfg[8*byte_sel +: 8] = preload_byte;

        case (state_q)
            S_RESET: begin
                k_d     = '0;
                state_d = (N_PRELOAD > 0) ? S_WR_ADDR : S_FINISH;
            end
            S_WR_ADDR: begin
                // Address goes first so a preloaded L bit cannot lock out its own pmpaddr
                fsm_addr  = pmpaddr_csr(kk);
                fsm_wen   = 1'b1;
                fsm_wdata = W_DATA'(PRELOAD_ADDR[32*kk +: 32]);
                state_d   = S_RD_CFG;
            end
            S_RD_CFG: begin
                fsm_addr   = pmpcfg_csr(kk);
                cfg_hold_d = pmp_cfg_rdata;
                state_d    = S_WR_CFG;
            end
            S_WR_CFG: begin
                fsm_addr  = pmpcfg_csr(kk);
                fsm_wen   = 1'b1;
                fsm_wdata = merged_cfg;
                state_d   = S_VERIFY;
            end
            S_VERIFY: begin
                // Only the cfg byte is checked; the PMP may legalise it (e.g. TOR reads as OFF)
                fsm_addr = pmpcfg_csr(kk);
                if (readback_byte != preload_byte) begin
                    error_d = 1'b1;
                end
                if (k_q == K_LAST) begin
                    state_d = S_FINISH;
                end else begin
                    k_d     = k_q + K_W'(1);
                    state_d = S_WR_ADDR;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            S_IDLE: begin
                // With nothing to preload a restart still walks RESET and FINISH
                if (start) begin
                    k_d     = '0;
                    error_d = 1'b0;
                    state_d = (N_PRELOAD > 0) ? S_WR_ADDR : S_RESET;
                end
            end
            default: begin
                state_d = S_RESET;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH);
    end

    // State and registered status flags; reset abandons any sequence in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RESET;
            k_q        <= '0;
            error_q    <= 1'b0;
            cfg_hold_q <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            error_q    <= error_d;
            cfg_hold_q <= cfg_hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Cfg port mux: CSR pass-through in IDLE, except the start cycle which is stalled
    always_comb begin
        idle = (state_q == S_IDLE);
        if (idle && !start) begin
            pmp_cfg_addr  = csr_addr;
            pmp_cfg_wen   = csr_wen;
            pmp_cfg_wdata = csr_wdata;
            csr_stall     = 1'b0;
        end else if (idle) begin
            pmp_cfg_addr  = csr_addr;
            pmp_cfg_wen   = 1'b0;
            pmp_cfg_wdata = csr_wdata;
            csr_stall     = 1'b1;
        end else begin
            pmp_cfg_addr  = fsm_addr;
            pmp_cfg_wen   = fsm_wen;
            pmp_cfg_wdata = fsm_wdata;
            csr_stall     = 1'b1;
        end
        csr_rdata = idle ? pmp_cfg_rdata : '0;
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

endmodule
